// File: rtl/mac_pkg.sv
// Shared MAC datapath definitions: FSM state type and default widths/lengths,
// used by the product accumulator and the multiplier wrapper.
package mac_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int MAC_PW  = 8;
  localparam int MAC_AW  = 16;
  localparam int MAC_LEN = 4;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle plus the synchronous abort (clr).
interface product_accumulator_if
  import mac_pkg::*;
#(
  parameter int PW = MAC_PW,
  parameter int AW = MAC_AW
);

  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_ovf;

  modport master (
    output clr, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  clr, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/product_accumulator_acc_add.sv
// acc_add: AW-bit signed add of the accumulator and a sign-extended product.
// With PRODUCT_ACCUMULATOR_SAT_EN defined the result clamps instead of wrapping.
module acc_add
  import mac_pkg::*;
#(
  parameter int PW = MAC_PW,
  parameter int AW = MAC_AW
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  logic [AW-1:0] prod_ext;
  logic [AW-1:0] raw_sum;

  assign prod_ext = AW'($signed(prod));
  assign raw_sum  = acc + prod_ext;
  // Overflow only when both operands share a sign the result does not.
  assign ovf      = (acc[AW-1] == prod_ext[AW-1]) && (raw_sum[AW-1] != acc[AW-1]);

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

  // Clamp toward the operands' common sign on overflow.
  always_comb begin
    sum = raw_sum;
    if (ovf) begin
      sum = acc[AW-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = raw_sum;
    end
  end
`else
  assign sum = raw_sum;
`endif

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN signed products per result and presents each sum on a
// registered valid/ready output. Optional macro PRODUCT_ACCUMULATOR_SAT_EN saturates adds.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PW  = MAC_PW,
  parameter int AW  = MAC_AW,
  parameter int LEN = MAC_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);

  localparam int             CW       = cnt_width(LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(LEN - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [AW-1:0] add_sum;
  logic          add_ovf;
  logic          accept;

  acc_add #(
    .PW (PW),
    .AW (AW)
  ) u_acc_add (
    .acc  (acc_q),
    .prod (bus.in_prod),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  assign accept = bus.in_valid && in_ready_q;

  // Next-state: accumulate in ACC, hold the result until taken; clr overrides everything.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (bus.clr) begin
      state_d     = ACC;
      acc_d       = {AW{1'b0}};
      cnt_d       = {CW{1'b0}};
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_q + CW'(1);
            ovf_d = ovf_q | add_ovf;
            if (cnt_q == CNT_LAST) begin
              state_d     = HOLD;
              out_sum_d   = add_sum;
              out_ovf_d   = ovf_q | add_ovf;
              out_valid_d = 1'b1;
            end else begin
              state_d = ACC;
            end
          end else begin
            state_d = ACC;
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            state_d     = ACC;
            acc_d       = {AW{1'b0}};
            cnt_d       = {CW{1'b0}};
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = ACC;
          acc_d       = {AW{1'b0}};
          cnt_d       = {CW{1'b0}};
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
    // Registered so that in_ready reads 0 throughout reset.
    in_ready_d = (state_d == ACC);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= {AW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      ovf_q       <= 1'b0;
      out_sum_q   <= {AW{1'b0}};
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
